cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the out-of-order core. It shares the four result-forwarding lanes between the functional-unit result producers: ALUs, load unit and branch unit. Each lane is a 23-bit forwarding bus consumed by the reservation-station queues (alu_queue and peers) and the ROB. Each producer gets a 2-entry skid buffer, and up to four buffered results are granted per cycle in round-robin order.

---
 rtl/ooo_pkg.sv | 28 ++
 rtl/cdb_skid_fifo.sv | 68 ++++++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: common-data-bus lane layout and the payload
// carried from a result producer to the bus.
package ooo_pkg;

  localparam int ROB_W     = 6;
  localparam int DATA_W    = 16;
  localparam int CDB_W     = 23;
  localparam int CDB_LANES = 4;

  localparam int CDB_VALID_BIT = 22;
  localparam int CDB_ROB_MSB   = 21;
  localparam int CDB_ROB_LSB   = 16;
  localparam int CDB_VAL_MSB   = 15;
  localparam int CDB_VAL_LSB   = 0;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] value;
  } cdb_payload_t;

  // Field order gives valid at bit 22, rob at 21:16, value at 15:0.
  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] value;
  } cdb_t;

endpackage

// File: rtl/cdb_skid_fifo.sv
// Two-entry skid buffer for one result producer. Head is always entry 0; a
// simultaneous push and pop at count 1 replaces the head with the new entry.
module cdb_skid_fifo
  import ooo_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  cdb_payload_t din,
  output cdb_payload_t head,
  output logic [1:0]   count,
  output logic         not_full
);

  cdb_payload_t head_q, head_d;
  cdb_payload_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         not_full_q, not_full_d;
  logic         do_push, do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && (count_q != 2'd2);
    do_pop  = pop && (count_q != 2'd0);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = din;
          else                 tail_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // Only reachable at count 1: the new entry becomes the head.
        2'b11: head_d = din;
        default: ;
      endcase
    end
    not_full_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  assign head     = head_q;
  assign count    = count_q;
  assign not_full = not_full_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one skid buffer per producer, up to four heads
// granted per cycle in round-robin order onto registered lanes A..D.
module cdb_arbiter
  import ooo_pkg::*;
#(
  parameter int NUM_REQ = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [CDB_W-1:0]          forwardA,
  output logic [CDB_W-1:0]          forwardB,
  output logic [CDB_W-1:0]          forwardC,
  output logic [CDB_W-1:0]          forwardD
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] push, pop, not_full, nonempty;
  cdb_payload_t       head  [NUM_REQ];
  logic [1:0]         count [NUM_REQ];

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t [CDB_LANES-1:0] lane_q, lane_d;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  assign req_ready = not_full;
  assign push      = req_valid & not_full & ~{NUM_REQ{flush}};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    cdb_payload_t din;
    assign din.rob   = req_rob[i*ROB_W +: ROB_W];
    assign din.value = req_value[i*DATA_W +: DATA_W];

    cdb_skid_fifo u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push[i]),
      .pop      (pop[i]),
      .din      (din),
      .head     (head[i]),
      .count    (count[i]),
      .not_full (not_full[i])
    );

    assign nonempty[i] = (count[i] != 2'd0);
  end

  // Rotate so rr_ptr sits at bit 0, then peel off the lowest set bit four times.
  logic [NUM_REQ-1:0]                rot, rem;
  logic [CDB_LANES-1:0]              found;
  logic [CDB_LANES-1:0][PTR_W-1:0]   pos, gidx;

  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = nonempty[wrap_add(rr_ptr_q, k)];
    end
    rem   = rot;
    found = '0;
    pos   = '0;
    gidx  = '0;
    for (int s = 0; s < CDB_LANES; s++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found[s] && rem[k]) begin
          found[s] = 1'b1;
          pos[s]   = PTR_W'(k);
        end
      end
      if (found[s]) rem[pos[s]] = 1'b0;
      gidx[s] = wrap_add(rr_ptr_q, int'(pos[s]));
    end
  end

  logic [PTR_W-1:0] last_idx;
  logic             any_grant;

  always_comb begin
    pop       = '0;
    lane_d    = '0;
    last_idx  = rr_ptr_q;
    any_grant = 1'b0;
    for (int s = 0; s < CDB_LANES; s++) begin
      if (found[s]) begin
        pop[gidx[s]]    = 1'b1;
        lane_d[s].valid = 1'b1;
        lane_d[s].rob   = head[gidx[s]].rob;
        lane_d[s].value = head[gidx[s]].value;
        last_idx        = gidx[s];
        any_grant       = 1'b1;
      end
    end
    rr_ptr_d = any_grant ? wrap_add(last_idx, 1) : rr_ptr_q;
    // Flush drops everything in flight but keeps fairness position.
    if (flush) begin
      pop      = '0;
      lane_d   = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      lane_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lane_q   <= lane_d;
    end
  end

  assign forwardA = lane_q[0];
  assign forwardB = lane_q[1];
  assign forwardC = lane_q[2];
  assign forwardD = lane_q[3];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a per-producer queue model.
module tb_cdb_arbiter;

  localparam int N = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*6-1:0]  req_rob;
  logic [N*16-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic [22:0]     forwardA, forwardB, forwardC, forwardD;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_rob   (req_rob),
    .req_value (req_value),
    .req_ready (req_ready),
    .forwardA  (forwardA),
    .forwardB  (forwardB),
    .forwardC  (forwardC),
    .forwardD  (forwardD)
  );

  logic [22:0] fw [4];
  assign fw[0] = forwardA;
  assign fw[1] = forwardB;
  assign fw[2] = forwardC;
  assign fw[3] = forwardD;

  int checks   = 0;
  int failures = 0;

  // Reference model: one FIFO queue per producer, a round-robin start index.
  logic [21:0] mq [N][$];
  int          m_rr;
  logic [22:0] exp_lane [4];
  logic [N-1:0] acc;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = (mq[p].size() < 2);
    return r;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [5:0] rob, input logic [15:0] val);
    req_valid[p]          = v;
    req_rob[p*6 +: 6]     = rob;
    req_value[p*16 +: 16] = val;
  endtask

  task automatic model_clear();
    for (int p = 0; p < N; p++) mq[p].delete();
    m_rr = 0;
    for (int k = 0; k < 4; k++) exp_lane[k] = '0;
  endtask

  // Apply current inputs across one rising edge and advance the model.
  task automatic cycle(input logic fl);
    logic [N-1:0] rdy;
    int n, last, p;
    flush = fl;
    @(posedge clk);
    rdy = exp_ready();
    acc = '0;
    for (int k = 0; k < 4; k++) exp_lane[k] = '0;
    if (fl) begin
      for (int q = 0; q < N; q++) mq[q].delete();
    end else begin
      n = 0;
      last = -1;
      for (int k = 0; k < N; k++) begin
        p = (m_rr + k) % N;
        if (n < 4 && mq[p].size() > 0) begin
          exp_lane[n] = {1'b1, mq[p].pop_front()};
          n++;
          last = p;
        end
      end
      if (last >= 0) m_rr = (last + 1) % N;
      for (int q = 0; q < N; q++) begin
        if (req_valid[q] && rdy[q]) begin
          mq[q].push_back({req_rob[q*6 +: 6], req_value[q*16 +: 16]});
          acc[q] = 1'b1;
        end
      end
    end
    #1;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    model_clear();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({forwardA, forwardB, forwardC, forwardD} !== '0) begin
      failures++;
      $display("FAIL reset_lanes got=%h %h %h %h exp=0", forwardA, forwardB, forwardC, forwardD);
    end
    checks++;
    if (req_ready !== 6'b111111) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=111111", req_ready);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 6'(p), 16'(p * 3 + 7));
    cycle(1'b0);
    cycle(1'b0);
    checks++;
    if (forwardA !== exp_lane[0] || forwardA[22] !== 1'b1) begin
      failures++;
      $display("FAIL reset_pretraffic got=%h exp=%h", forwardA, exp_lane[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({forwardA, forwardB, forwardC, forwardD} !== '0) begin
      failures++;
      $display("FAIL reset_mid_lanes got=%h %h %h %h exp=0", forwardA, forwardB, forwardC, forwardD);
    end
    checks++;
    if (req_ready !== 6'b111111) begin
      failures++;
      $display("FAIL reset_mid_ready got=%b exp=111111", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0);
      checks++;
      if ({forwardA, forwardB, forwardC, forwardD} !== '0) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%h %h %h %h exp=0", c, forwardA, forwardB, forwardC, forwardD);
      end
    end
  endtask

  task automatic test_single_push();
    do_reset();
    set_req(2, 1'b1, 6'd5, 16'h1234);
    cycle(1'b0);
    req_valid = '0;
    checks++;
    if ({forwardA, forwardB, forwardC, forwardD} !== '0) begin
      failures++;
      $display("FAIL single_early got=%h exp=0", forwardA);
    end
    cycle(1'b0);
    checks++;
    if (forwardA !== 23'h451234) begin
      failures++;
      $display("FAIL single_laneA got=%h exp=451234", forwardA);
    end
    checks++;
    if ({forwardB, forwardC, forwardD} !== '0) begin
      failures++;
      $display("FAIL single_laneBCD got=%h %h %h exp=0", forwardB, forwardC, forwardD);
    end
    // rr_ptr should now be 3: producer 3 outranks producer 0.
    set_req(0, 1'b1, 6'h0A, 16'hAAAA);
    set_req(3, 1'b1, 6'h0B, 16'hBBBB);
    cycle(1'b0);
    req_valid = '0;
    cycle(1'b0);
    checks++;
    if (forwardA !== {1'b1, 6'h0B, 16'hBBBB} || forwardB !== {1'b1, 6'h0A, 16'hAAAA}) begin
      failures++;
      $display("FAIL single_rrptr got=%h %h exp=%h %h", forwardA, forwardB,
               {1'b1, 6'h0B, 16'hBBBB}, {1'b1, 6'h0A, 16'hAAAA});
    end
  endtask

  task automatic test_all_six();
    logic [22:0] e;
    do_reset();
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 6'(p + 16), 16'hC000 + 16'(p));
    cycle(1'b0);
    req_valid = '0;
    cycle(1'b0);
    for (int k = 0; k < 4; k++) begin
      e = {1'b1, 6'(k + 16), 16'hC000 + 16'(k)};
      checks++;
      if (fw[k] !== e) begin
        failures++;
        $display("FAIL all6_first lane%0d got=%h exp=%h", k, fw[k], e);
      end
    end
    cycle(1'b0);
    for (int k = 0; k < 2; k++) begin
      e = {1'b1, 6'(k + 20), 16'hC000 + 16'(k + 4)};
      checks++;
      if (fw[k] !== e) begin
        failures++;
        $display("FAIL all6_second lane%0d got=%h exp=%h", k, fw[k], e);
      end
    end
    checks++;
    if ({forwardC, forwardD} !== '0) begin
      failures++;
      $display("FAIL all6_second_CD got=%h %h exp=0", forwardC, forwardD);
    end
  endtask

  task automatic test_saturation();
    int seqn [N];
    int lastg [N];
    int maxgap [N];
    logic saw_drop;
    do_reset();
    saw_drop = 1'b0;
    for (int p = 0; p < N; p++) begin
      seqn[p] = 0;
      lastg[p] = 1;
      maxgap[p] = 0;
      set_req(p, 1'b1, {3'(p), 3'd0}, 16'($urandom));
    end
    for (int c = 1; c <= 24; c++) begin
      if (c > 20) req_valid = '0;
      cycle(1'b0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (fw[k] !== exp_lane[k]) begin
          failures++;
          $display("FAIL sat_lane c=%0d lane%0d got=%h exp=%h", c, k, fw[k], exp_lane[k]);
        end
        if (fw[k][22] && int'(fw[k][21:19]) < N) lastg[fw[k][21:19]] = c;
      end
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++;
        $display("FAIL sat_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      if (req_ready != '1) saw_drop = 1'b1;
      if (c <= 20)
        for (int p = 0; p < N; p++)
          if (c - lastg[p] > maxgap[p]) maxgap[p] = c - lastg[p];
      for (int p = 0; p < N; p++) begin
        if (acc[p] && c < 20) begin
          seqn[p]++;
          set_req(p, 1'b1, {3'(p), 3'(seqn[p])}, 16'($urandom));
        end
      end
    end
    checks++;
    if (saw_drop !== 1'b1) begin
      failures++;
      $display("FAIL sat_ready_drop got=%b exp=1", saw_drop);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (maxgap[p] > 1) begin
        failures++;
        $display("FAIL sat_starve p=%0d got_gap=%0d exp_max=1", p, maxgap[p]);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_req(0, 1'b1, 6'h01, 16'h1111);
    cycle(1'b0);
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL samecyc_ready1 got=%b exp=1", req_ready[0]);
    end
    set_req(0, 1'b1, 6'h02, 16'h2222);
    cycle(1'b0);
    req_valid = '0;
    checks++;
    if (forwardA !== {1'b1, 6'h01, 16'h1111}) begin
      failures++;
      $display("FAIL samecyc_first got=%h exp=%h", forwardA, {1'b1, 6'h01, 16'h1111});
    end
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL samecyc_ready2 got=%b exp=1", req_ready[0]);
    end
    cycle(1'b0);
    checks++;
    if (forwardA !== {1'b1, 6'h02, 16'h2222}) begin
      failures++;
      $display("FAIL samecyc_second got=%h exp=%h", forwardA, {1'b1, 6'h02, 16'h2222});
    end
    cycle(1'b0);
    checks++;
    if (forwardA !== '0) begin
      failures++;
      $display("FAIL samecyc_empty got=%h exp=0", forwardA);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 6'(p), 16'h5000 + 16'(p));
    cycle(1'b0);
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 6'(p + 8), 16'h6000 + 16'(p));
    cycle(1'b0);
    checks++;
    if (req_ready !== 6'b001111) begin
      failures++;
      $display("FAIL flush_prefill_ready got=%b exp=001111", req_ready);
    end
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 6'(p + 32), 16'h7000 + 16'(p));
    cycle(1'b1);
    req_valid = '0;
    checks++;
    if ({forwardA, forwardB, forwardC, forwardD} !== '0) begin
      failures++;
      $display("FAIL flush_lanes got=%h %h %h %h exp=0", forwardA, forwardB, forwardC, forwardD);
    end
    checks++;
    if (req_ready !== 6'b111111) begin
      failures++;
      $display("FAIL flush_ready got=%b exp=111111", req_ready);
    end
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0);
      checks++;
      if ({forwardA, forwardB, forwardC, forwardD} !== '0) begin
        failures++;
        $display("FAIL flush_after c=%0d got=%h %h %h %h exp=0", c, forwardA, forwardB, forwardC, forwardD);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pend[p] = 1'b1;
          set_req(p, 1'b1, 6'($urandom), 16'($urandom));
        end
        req_valid[p] = pend[p];
      end
      cycle(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (fw[k] !== exp_lane[k]) begin
          failures++;
          $display("FAIL rand_lane c=%0d lane%0d got=%h exp=%h", c, k, fw[k], exp_lane[k]);
        end
      end
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++;
        $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      pend = pend & ~acc;
    end
  endtask

  initial begin
    flush     = 1'b0;
    req_valid = '0;
    req_rob   = '0;
    req_value = '0;
    model_clear();
    test_reset();
    test_single_push();
    test_all_six();
    test_saturation();
    test_same_cycle();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
